scoreboard_hazard_unit: RTL and testbench
=========================================

# scoreboard_hazard_unit

Parametrised hazard controller for the pipelined MIPS core, placed between decode and the pipeline-register enables. It generalises the fixed load-use stall logic into a per-register pending-write scoreboard that supports variable-latency producers such as ALU, load and multi-cycle mult/div. It also adds branch flush, a memory-wait freeze and a saturating stall counter. It drives PC and pipeline-latch enables/flushes and is the single source of stall decisions for decode.

## Interface
Parameters:
- NREGS, 32, architectural register count; register 0 is hard-wired zero.
- REGW, 5, register index width (matches regbits_t).
- MAXLAT, 7, largest producer latency tracked; larger requests clamp to MAXLAT.
- LATW, 3, latency field width; MAXLAT must fit.
- CNTW, 32, stall performance counter width.

Ports:
- CLK  in  1  core clock; all state updates on its rising edge.
- RST  in  1  reset, synchronous, active-high.
- ihit  in  1  fetch has a valid instruction this cycle.
- mem_wait  in  1  memory stage not done (dcache miss); freezes the whole pipeline.
- branch_taken  in  1  EX resolved a taken branch or jump.
- issue_valid  in  1  decode holds a valid instruction.
- rs, rt  in  REGW each  decode source registers.
- rs_used, rt_used  in  1 each  the source is actually read.
- rd  in  REGW  decode destination register.
- rd_wen  in  1  the instruction writes rd.
- lat  in  LATW  cycles before rd becomes forwardable; 0 means available by forwarding next cycle.
- issue  out  1  decode instruction advances to EX this cycle.
- stall  out  1  data hazard is holding decode.
- pcEN, fdEN  out  1 each  PC and fetch/decode latch enables.
- fd_flush, dx_flush  out  1 each  bubble-insert into the F/D and D/X latches.
- pend_mask  out  NREGS  bit r is 1 while pend[r] != 0.
- stall_cnt  out  CNTW  number of cycles with stall=1, saturating.

## Operation
- State: pend[r] (LATW bits) for r = 1 to NREGS-1. pend[0] is constant 0. stall_cnt also holds state.
- A source is pending when it is used, its register is non-zero, and pend of that register is non-zero.
- WAW hazard: rd_wen, rd != 0 and pend[rd] != 0.
- haz = issue_valid & (rs pending | rt pending | WAW).
- stall = haz & ~mem_wait & ~branch_taken. A branch squashes the decode instruction, so it never stalls.
- issue = issue_valid & ~haz & ~mem_wait & ~branch_taken.
- pcEN = ~mem_wait & (branch_taken | (ihit & ~stall)).
- fdEN = pcEN.
- fd_flush = branch_taken & ~mem_wait, plus fetch miss: ~ihit & ~stall & ~mem_wait.
- dx_flush = ~mem_wait & (stall | branch_taken | ~issue_valid).
- Scoreboard update happens when mem_wait=0. mem_wait=1 freezes all pend values.
  - Every non-zero pend decrements by 1.
  - If issue & rd_wen & rd != 0, pend[rd] is loaded with min(lat, MAXLAT). The load overrides the decrement of the same register.
- stall_cnt increments when stall=1 and holds at all-ones.
- RST=1 (synchronous, takes precedence over everything):
  - pend and stall_cnt clear to 0.
  - While RST=1: pcEN=0, fdEN=0, issue=0, stall=0, fd_flush=1, dx_flush=1, pend_mask=0.

## Timing
- All outputs are combinational from inputs and current state. Scoreboard changes are visible the cycle after the edge.
- Producer issued at cycle t with lat=L:
  - A dependent instruction in decode stalls in cycles t+1 through t+L.
  - It issues at t+L+1.
  - lat=0 gives no stall; lat=1 (load-use) gives exactly one bubble.
- mem_wait cycles extend each stall window 1:1, because counters are frozen.
- Branch and hazard in the same cycle: the flush wins, stall=0, and stall_cnt does not count it.
- RST asserted mid-stall: next cycle all pend=0, and any issue_valid instruction issues at once after RST falls.

## Test plan
- Reset: hold RST 2 cycles with arbitrary inputs -> pend_mask=0, stall_cnt=0, pcEN=0, dx_flush=1. Release -> a back-to-back independent stream issues every cycle.
- Load-use: issue rd=5 with lat=1, then issue rs=5 -> stall=1, dx_flush=1, pcEN=0 for 1 cycle. Issue happens the following cycle, and stall_cnt=1.
- Mult latency: rd=8 with lat=4, then a consumer with rt=8 -> 4 stall cycles. Insert mem_wait for 2 of them -> 6 cycles total; pend_mask[8] stays high while frozen.
- Register 0 and unused sources: rd=0 with lat=7, then rs=0 -> no stall. rt=8 pending with rt_used=0 -> no stall.
- WAW plus clamp: rd=3 with lat=7, then rd=3 with lat=1 -> stall until pend[3]=0. Then lat=15 loads 7 (MAXLAT).
- Simultaneous: hazard together with branch_taken -> stall=0, issue=0, fd_flush=1, dx_flush=1, pcEN=1. Drive stall_cnt to saturation -> it holds at all-ones.

Source files
------------

// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit: per-register pending-write scoreboard driving stall, flush and pipeline enables
module scoreboard_hazard_unit #(
  parameter int NREGS  = 32,
  parameter int REGW   = 5,
  parameter int MAXLAT = 7,
  parameter int LATW   = 3,
  parameter int CNTW   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             mem_wait,
  input  logic             branch_taken,
  input  logic             issue_valid,
  input  logic [REGW-1:0]  rs,
  input  logic [REGW-1:0]  rt,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic [REGW-1:0]  rd,
  input  logic             rd_wen,
  input  logic [LATW-1:0]  lat,
  output logic             issue,
  output logic             stall,
  output logic             pcEN,
  output logic             fdEN,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic [NREGS-1:0] pend_mask,
  output logic [CNTW-1:0]  stall_cnt
);
  localparam logic [LATW-1:0] MAXL = LATW'(MAXLAT);
  logic [LATW-1:0] pend_q [NREGS];
  logic [LATW-1:0] pend_d [NREGS];
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic rs_pend, rt_pend, waw, haz, stall_c, issue_c, load;
  logic [LATW-1:0] lat_c;
  always_comb begin
    rs_pend = rs_used && rs != '0 && pend_q[rs] != '0;
    rt_pend = rt_used && rt != '0 && pend_q[rt] != '0;
    waw = rd_wen && rd != '0 && pend_q[rd] != '0;
    haz = issue_valid && (rs_pend || rt_pend || waw);
    stall_c = haz && !mem_wait && !branch_taken;
    issue_c = issue_valid && !haz && !mem_wait && !branch_taken;
    load = issue_c && rd_wen && rd != '0;
    lat_c = (lat > MAXL) ? MAXL : lat;
    issue = !RST && issue_c;
    stall = !RST && stall_c;
    pcEN = !RST && !mem_wait && (branch_taken || (ihit && !stall_c));
    fdEN = pcEN;
    fd_flush = RST || (!mem_wait && (branch_taken || (!ihit && !stall_c)));
    dx_flush = RST || (!mem_wait && (stall_c || branch_taken || !issue_valid));
    pend_mask = '0;
    for (int r = 0; r < NREGS; r++) begin
      pend_mask[r] = !RST && pend_q[r] != '0;
      // a fresh load wins over the countdown of the same register
      pend_d[r] = mem_wait ? pend_q[r] :
                  (load && rd == REGW'(r)) ? lat_c :
                  pend_q[r] - LATW'(pend_q[r] != '0);
    end
    pend_d[0] = '0;
    stall_cnt_d = (stall_c && stall_cnt_q != '1) ? stall_cnt_q + CNTW'(1) : stall_cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NREGS; r++) pend_q[r] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) pend_q[r] <= pend_d[r];
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// tb_scoreboard_hazard_unit: directed checks of the hazard scoreboard (LATW=4 for clamp, CNTW=4 for saturation)
module tb_scoreboard_hazard_unit;
  logic        CLK = 1'b0;
  logic        RST, ihit, mem_wait, branch_taken, issue_valid;
  logic [4:0]  rs, rt, rd;
  logic        rs_used, rt_used, rd_wen;
  logic [3:0]  lat;
  logic        issue, stall, pcEN, fdEN, fd_flush, dx_flush;
  logic [31:0] pend_mask;
  logic [3:0]  stall_cnt;
  logic [5:0]  mwv;
  int checks = 0;
  int errors = 0;

  scoreboard_hazard_unit #(.NREGS(32), .REGW(5), .MAXLAT(7), .LATW(4), .CNTW(4)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .mem_wait(mem_wait), .branch_taken(branch_taken),
    .issue_valid(issue_valid), .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used),
    .rd(rd), .rd_wen(rd_wen), .lat(lat), .issue(issue), .stall(stall), .pcEN(pcEN),
    .fdEN(fdEN), .fd_flush(fd_flush), .dx_flush(dx_flush), .pend_mask(pend_mask),
    .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ins(input logic v, input logic [4:0] s, input logic su, input logic [4:0] t,
                     input logic tu, input logic [4:0] d, input logic w, input logic [3:0] l);
    issue_valid = v; rs = s; rs_used = su; rt = t; rt_used = tu; rd = d; rd_wen = w; lat = l;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1; ihit = 0; mem_wait = 0; branch_taken = 0;
    ins(1, 5, 1, 6, 1, 5, 1, 7);
    #1;
    chk("rst_pcEN", pcEN, 0);
    chk("rst_fdEN", fdEN, 0);
    chk("rst_issue", issue, 0);
    chk("rst_stall", stall, 0);
    chk("rst_fd_flush", fd_flush, 1);
    chk("rst_dx_flush", dx_flush, 1);
    tick; tick;
    chk("rst_mask", pend_mask, 0);
    chk("rst_cnt", stall_cnt, 0);
    RST = 0; ihit = 1;
    ins(1, 9, 1, 0, 0, 1, 1, 0);
    #1;
    chk("s0_issue", issue, 1);
    chk("s0_pcEN", pcEN, 1);
    chk("s0_dx_flush", dx_flush, 0);
    chk("s0_fd_flush", fd_flush, 0);
    tick;
    ins(1, 1, 1, 2, 1, 2, 1, 0);
    #1;
    chk("s1_issue", issue, 1);
    chk("s1_stall", stall, 0);
    tick;
    ins(1, 2, 1, 1, 1, 3, 1, 0);
    #1;
    chk("s2_issue", issue, 1);
    tick;
    ihit = 0;
    ins(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("miss_fd_flush", fd_flush, 1);
    chk("miss_pcEN", pcEN, 0);
    chk("miss_issue", issue, 1);
    tick;
    ihit = 1;
    // load-use: one bubble
    ins(1, 0, 0, 0, 0, 5, 1, 1);
    #1;
    chk("ld_issue", issue, 1);
    tick;
    ins(1, 5, 1, 0, 0, 6, 1, 0);
    #1;
    chk("lu_stall", stall, 1);
    chk("lu_dx_flush", dx_flush, 1);
    chk("lu_pcEN", pcEN, 0);
    chk("lu_fdEN", fdEN, 0);
    chk("lu_issue", issue, 0);
    chk("lu_mask5", pend_mask[5], 1);
    tick;
    #1;
    chk("lu2_issue", issue, 1);
    chk("lu2_stall", stall, 0);
    chk("lu2_cnt", stall_cnt, 1);
    tick;
    // mult lat=4 with two frozen cycles
    ins(1, 0, 0, 0, 0, 8, 1, 4);
    #1;
    chk("mul_issue", issue, 1);
    tick;
    ins(1, 0, 0, 8, 1, 9, 1, 0);
    mwv = 6'b000110;
    for (int i = 0; i < 6; i++) begin
      mem_wait = mwv[i];
      #1;
      chk("mul_stall", stall, {31'b0, ~mwv[i]});
      chk("mul_issue_hold", issue, 0);
      chk("mul_mask8", pend_mask[8], 1);
      chk("mul_pcEN", pcEN, 0);
      tick;
    end
    mem_wait = 0;
    #1;
    chk("mul_go", issue, 1);
    chk("mul_cnt", stall_cnt, 5);
    tick;
    // register 0 and unused sources
    ins(1, 0, 0, 0, 0, 0, 1, 7);
    #1;
    chk("r0_issue", issue, 1);
    tick;
    ins(1, 0, 1, 0, 1, 10, 1, 0);
    #1;
    chk("r0_use_issue", issue, 1);
    chk("r0_use_stall", stall, 0);
    chk("r0_mask", pend_mask, 0);
    tick;
    ins(1, 0, 0, 0, 0, 8, 1, 2);
    #1;
    chk("p8_issue", issue, 1);
    tick;
    ins(1, 0, 0, 8, 0, 11, 1, 0);
    #1;
    chk("unused_mask", pend_mask, 32'h100);
    chk("unused_issue", issue, 1);
    chk("unused_stall", stall, 0);
    tick;
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("idle_issue", issue, 0);
    chk("idle_dx_flush", dx_flush, 1);
    chk("idle_pcEN", pcEN, 1);
    tick;
    // WAW then clamp
    ins(1, 0, 0, 0, 0, 3, 1, 7);
    #1;
    chk("waw0_issue", issue, 1);
    tick;
    ins(1, 0, 0, 0, 0, 3, 1, 1);
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("waw_stall", stall, 1);
      tick;
    end
    #1;
    chk("waw_go", issue, 1);
    chk("waw_cnt", stall_cnt, 12);
    tick;
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("waw_clear", pend_mask, 0);
    ins(1, 0, 0, 0, 0, 3, 1, 15);
    #1;
    chk("clamp_issue", issue, 1);
    tick;
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("clamp_mask3", pend_mask[3], 1);
      tick;
    end
    #1;
    chk("clamp_done", pend_mask, 0);
    // branch beats hazard
    ins(1, 0, 0, 0, 0, 4, 1, 2);
    #1;
    chk("br_prod_issue", issue, 1);
    tick;
    ins(1, 4, 1, 0, 0, 12, 1, 0);
    branch_taken = 1;
    #1;
    chk("br_stall", stall, 0);
    chk("br_issue", issue, 0);
    chk("br_fd_flush", fd_flush, 1);
    chk("br_dx_flush", dx_flush, 1);
    chk("br_pcEN", pcEN, 1);
    tick;
    branch_taken = 0;
    ins(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("br_cnt", stall_cnt, 12);
    tick;
    // saturation: 7 more stalls from 12 must stop at 15
    ins(1, 0, 0, 0, 0, 4, 1, 7);
    tick;
    ins(1, 4, 1, 0, 0, 12, 1, 0);
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("sat_stall", stall, 1);
      tick;
    end
    #1;
    chk("sat_go", issue, 1);
    chk("sat_cnt", stall_cnt, 15);
    tick;
    // reset in the middle of a stall
    ins(1, 0, 0, 0, 0, 7, 1, 5);
    tick;
    ins(1, 7, 1, 0, 0, 13, 1, 0);
    #1;
    chk("rm_stall", stall, 1);
    tick;
    RST = 1;
    #1;
    chk("rm_rst_stall", stall, 0);
    chk("rm_rst_issue", issue, 0);
    chk("rm_rst_fd_flush", fd_flush, 1);
    chk("rm_rst_pcEN", pcEN, 0);
    chk("rm_rst_mask", pend_mask, 0);
    tick;
    RST = 0;
    #1;
    chk("rm_issue", issue, 1);
    chk("rm_stall2", stall, 0);
    chk("rm_cnt", stall_cnt, 0);
    chk("rm_mask", pend_mask, 0);
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
